// File: rtl/gray_sync_rx.sv
// gray_sync_rx
//   Receive-side endpoint for a Gray-coded counter launched from another
//   clock domain. The Gray bus passes through a SYNC_STAGES flop chain. It is
//   then decoded to binary and tracked. Any forward step larger than MAX_STEP
//   (modulo 2^WIDTH) is flagged as an illegal jump.
//
// Ports
//   clk        destination-domain clock
//   rstb       asynchronous active-low reset (release synchronised externally)
//   gray_in    Gray-coded count, asynchronous to clk
//   clr_err    synchronous clear for err_jump / jump_cnt
//   bin_val    registered binary value of the synchronised Gray input
//   val_chg    one-cycle pulse when bin_val updates while tracking
//   delta      registered (new - old) mod 2^WIDTH of the last update
//   ready      high once the synchroniser has been flushed (TRACK state)
//   err_jump   sticky flag: an update had delta > MAX_STEP
//   jump_cnt   number of illegal jumps, saturating at 255
//   dbg_state  current FSM state encoding (ST_FLUSH / ST_TRACK)
//
// FSM: FLUSH waits SYNC_STAGES+1 edges after reset so that stale chain
// contents never count as an update. TRACK then compares every decoded
// sample against bin_val.

module gray_sync_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int MAX_STEP    = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_val,
    output logic             val_chg,
    output logic [WIDTH-1:0] delta,
    output logic             ready,
    output logic             err_jump,
    output logic [7:0]       jump_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'b01,
        ST_TRACK = 2'b10
    } state_t;

    // SYNC_STAGES + 1 is at most 5, so 3 bits cover the flush count.
    localparam logic [2:0]       FLUSH_DONE = 3'(SYNC_STAGES + 1);
    localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    state_t           r_state;
    logic [2:0]       r_flush_cnt;
    logic [WIDTH-1:0] r_bin_val;
    logic             r_val_chg;
    logic [WIDTH-1:0] r_delta;
    logic             r_ready;
    logic             r_err_jump;
    logic [7:0]       r_jump_cnt;

    logic [WIDTH-1:0] w_gs;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    logic             w_jump;
    logic [2:0]       w_flush_nxt;
    logic [7:0]       w_cnt_inc;

    // Synchroniser chain: stage 0 captures the asynchronous bus.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= gray_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_gs = r_sync[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(w_gs >> i);
        end
    end

    // Unsigned WIDTH-bit subtraction wraps naturally, so all-ones -> 0 is +1.
    assign w_diff      = w_bin - r_bin_val;
    assign w_jump      = (w_diff > MAX_STEP_W);
    assign w_flush_nxt = r_flush_cnt + 3'd1;
    assign w_cnt_inc   = (r_jump_cnt == 8'hFF) ? 8'hFF : r_jump_cnt + 8'd1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
            r_bin_val   <= '0;
            r_val_chg   <= 1'b0;
            r_delta     <= '0;
            r_ready     <= 1'b0;
            r_err_jump  <= 1'b0;
            r_jump_cnt  <= '0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    r_flush_cnt <= w_flush_nxt;
                    r_bin_val   <= w_bin;
                    if (w_flush_nxt == FLUSH_DONE) begin
                        r_state <= ST_TRACK;
                        r_ready <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (w_diff == '0) begin
                        r_val_chg <= 1'b0;
                    end else begin
                        r_bin_val <= w_bin;
                        r_delta   <= w_diff;
                        r_val_chg <= 1'b1;
                    end
                    // A jump detected on the same edge as clr_err wins:
                    // the counter restarts at 1 rather than 0.
                    if ((w_diff != '0) && w_jump) begin
                        r_err_jump <= 1'b1;
                        r_jump_cnt <= clr_err ? 8'd1 : w_cnt_inc;
                    end else if (clr_err) begin
                        r_err_jump <= 1'b0;
                        r_jump_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_FLUSH;
                    r_flush_cnt <= '0;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign bin_val   = r_bin_val;
    assign val_chg   = r_val_chg;
    assign delta     = r_delta;
    assign ready     = r_ready;
    assign err_jump  = r_err_jump;
    assign jump_cnt  = r_jump_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gray_sync_rx.sv
// Testbench for gray_sync_rx (WIDTH=4, SYNC_STAGES=2, MAX_STEP=1).
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// same point, well away from the next active edge.

module tb_gray_sync_rx;

    logic       clk;
    logic       rstb;
    logic [3:0] gray_in;
    logic       clr_err;
    logic [3:0] bin_val;
    logic       val_chg;
    logic [3:0] delta;
    logic       ready;
    logic       err_jump;
    logic [7:0] jump_cnt;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    gray_sync_rx #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .MAX_STEP(1)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .gray_in(gray_in),
        .clr_err(clr_err),
        .bin_val(bin_val),
        .val_chg(val_chg),
        .delta(delta),
        .ready(ready),
        .err_jump(err_jump),
        .jump_cnt(jump_cnt),
        .dbg_state(dbg_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    // Reset with gray_in held at g, release, then run the three flush edges.
    task automatic reset_and_flush(input logic [3:0] g);
        rstb    = 1'b0;
        gray_in = g;
        clr_err = 1'b0;
        ticks(3);
        rstb = 1'b1;
        ticks(3);
    endtask

    initial begin
        int pulses;
        int v;

        rstb    = 1'b0;
        gray_in = 4'b0111;
        clr_err = 1'b0;

        // ---------------- reset / flush defaults ----------------
        ticks(3);
        check("rst_bin_val", bin_val, 0);
        check("rst_ready", ready, 0);
        check("rst_val_chg", val_chg, 0);
        check("rst_delta", delta, 0);
        check("rst_err", err_jump, 0);
        check("rst_cnt", jump_cnt, 0);
        rstb   = 1'b1;
        pulses = 0;
        tick();
        check("flush_e1_ready", ready, 0);
        pulses += val_chg;
        tick();
        check("flush_e2_ready", ready, 0);
        pulses += val_chg;
        tick();
        check("flush_e3_ready", ready, 1);
        check("flush_e3_bin", bin_val, 5);
        pulses += val_chg;
        ticks(2);
        pulses += val_chg;
        check("flush_no_pulse", pulses, 0);
        check("flush_err", err_jump, 0);

        // ---------------- latency ----------------
        reset_and_flush(4'b0000);
        check("lat_start_bin", bin_val, 0);
        gray_in = 4'b0001;                 // just before edge n
        tick();                            // edge n
        check("lat_n_chg", val_chg, 0);
        tick();                            // edge n+1
        check("lat_n1_chg", val_chg, 0);
        check("lat_n1_bin", bin_val, 0);
        tick();                            // edge n+2
        check("lat_n2_bin", bin_val, 1);
        check("lat_n2_delta", delta, 1);
        check("lat_n2_chg", val_chg, 1);
        tick();                            // edge n+3
        check("lat_n3_chg", val_chg, 0);

        // ---------------- full count with wrap ----------------
        reset_and_flush(4'b0000);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            gray_in = to_gray(i % 16);
            for (int t = 0; t < 10; t++) begin
                tick();
                pulses += val_chg;
            end
            check("cnt_bin", bin_val, i % 16);
            check("cnt_delta", delta, 1);
        end
        check("cnt_pulses", pulses, 16);
        check("cnt_err", err_jump, 0);
        check("cnt_jumps", jump_cnt, 0);

        // ---------------- illegal jump ----------------
        reset_and_flush(4'b0000);
        gray_in = 4'b0010;                 // binary 3
        ticks(3);
        check("jump_delta", delta, 3);
        check("jump_chg", val_chg, 1);
        check("jump_err", err_jump, 1);
        check("jump_cnt", jump_cnt, 1);
        gray_in = to_gray(4);              // legal step 3 -> 4
        ticks(3);
        check("legal_delta", delta, 1);
        check("legal_bin", bin_val, 4);
        check("legal_err_sticky", err_jump, 1);
        check("legal_cnt", jump_cnt, 1);

        // ---------------- clear collision and saturation ----------------
        gray_in = to_gray(7);              // 4 -> 7, second illegal jump
        ticks(3);
        check("jump2_cnt", jump_cnt, 2);
        gray_in = to_gray(10);             // 7 -> 10, detected at the third edge
        ticks(2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("coll_bin", bin_val, 10);
        check("coll_err", err_jump, 1);
        check("coll_cnt", jump_cnt, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", err_jump, 0);
        check("clr_cnt", jump_cnt, 0);

        v = 10;
        for (int j = 0; j < 300; j++) begin
            v = (v + 3) % 16;
            gray_in = to_gray(v);
            ticks(3);
        end
        check("sat_bin", bin_val, 14);
        check("sat_cnt", jump_cnt, 255);
        check("sat_err", err_jump, 1);

        // ---------------- reset mid-run ----------------
        gray_in = to_gray(9);
        ticks(3);
        check("mid_bin", bin_val, 9);
        check("mid_err", err_jump, 1);
        #2;
        rstb = 1'b0;                       // no clock edge before the checks
        #1;
        check("async_bin", bin_val, 0);
        check("async_delta", delta, 0);
        check("async_ready", ready, 0);
        check("async_err", err_jump, 0);
        check("async_cnt", jump_cnt, 0);
        check("async_chg", val_chg, 0);
        ticks(2);
        rstb = 1'b1;
        tick();
        check("rel_e1_ready", ready, 0);
        tick();
        check("rel_e2_ready", ready, 0);
        tick();
        check("rel_e3_ready", ready, 1);
        check("rel_e3_bin", bin_val, 9);
        check("rel_e3_err", err_jump, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_sync_rx.md
Name: gray_sync_rx

Overview:
- Receive-side endpoint for a Gray-coded counter that is sent from another clock domain.
- Synchronises the asynchronous Gray bus through a flop chain, then decodes it to binary.
- Tracks the step size between successive decoded values and flags illegal multi-step jumps, which indicate a sender running too fast or a bus that is not single-bit-change.
- Sits in the destination domain. It is the consumer end of the gray_sync path.

Parameters:
- WIDTH, 4, width of the Gray bus and of the decoded value.
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- MAX_STEP, 1, largest legal forward step per update, counted modulo 2^WIDTH.

Ports:
- clk  in  1  destination-domain clock.
- rstb  in  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to clk, handled externally.
- gray_in  in  WIDTH  Gray-coded count, asynchronous to clk.
- clr_err  in  1  synchronous clear for err_jump and jump_cnt.
- bin_val  out  WIDTH  registered binary value of the synchronised Gray input.
- val_chg  out  1  one-cycle pulse when bin_val updates in the TRACK state.
- delta  out  WIDTH  registered (new - old) mod 2^WIDTH of the last update.
- ready  out  1  high once the synchroniser is flushed (TRACK state).
- err_jump  out  1  sticky flag: an update had delta > MAX_STEP.
- jump_cnt  out  8  count of illegal jumps, saturating at 255.

Behaviour:
- Reset (rstb=0, asynchronous): all sync flops 0, bin_val=0, val_chg=0, delta=0, ready=0, err_jump=0, jump_cnt=0, flush counter=0, state=FLUSH.
- Sync chain: stage1 <= gray_in; stage k <= stage k-1; g_s = last stage. b = gray2bin(g_s), combinational XOR-prefix, MSB first.
- Latency:
  - gray_in stable at edge n is in stage1 at n.
  - It reaches g_s at edge n+SYNC_STAGES-1.
  - bin_val, delta and val_chg update at edge n+SYNC_STAGES.
- FLUSH state:
  - Flush counter increments every edge.
  - bin_val <= b every edge.
  - val_chg, delta, err_jump and jump_cnt are untouched and no jump check is performed.
  - When the counter reaches SYNC_STAGES+1 (first edge with rstb=1 is edge 1), go to TRACK and set ready=1 on that edge.
- TRACK state, every edge:
  - Compute d = (b - bin_val) mod 2^WIDTH, WIDTH-bit unsigned subtraction with wrap.
  - If d == 0: val_chg <= 0; bin_val and delta hold.
  - If d != 0: bin_val <= b, delta <= d, val_chg <= 1.
  - If additionally d > MAX_STEP: err_jump <= 1 and jump_cnt <= min(jump_cnt+1, 255).
- Wrap-around: all-ones -> 0 gives d=1, which is legal.
- Backward moves: a backward step of 1 gives d = 2^WIDTH-1, which is illegal when MAX_STEP < 2^WIDTH-1.
- clr_err: at the next edge err_jump <= 0 and jump_cnt <= 0. If an illegal jump is detected on the same edge, the jump wins: err_jump=1, jump_cnt=1.
- jump_cnt saturates at 255 and never wraps. err_jump stays 1 until clr_err or reset.
- val_chg is never high for two consecutive cycles unless b differs on consecutive edges, since each edge compares against the updated bin_val.
- Reset mid-operation: all outputs clear asynchronously. The state returns to FLUSH and the full SYNC_STAGES+1 flush repeats after release.
- The state register has only FLUSH and TRACK. Any unreachable encoding goes to FLUSH.

Test Plan:
- Reset/flush, defaults:
  - Stimulus: hold gray_in=4'b0111 (bin 5) through reset, release rstb.
  - Response: ready=0 for edges 1-2, ready=1 at edge 3, bin_val=5, val_chg never pulses, err_jump=0.
- Latency:
  - Stimulus: in TRACK with bin_val=0, set gray_in=4'b0001 just before edge n.
  - Response: bin_val=1, delta=1 and val_chg=1 at edge n+2 only; val_chg=0 at n+3.
- Full count with wrap:
  - Stimulus: step gray_in through the Gray sequence 0..15 then back to 0, one change every 10 clk cycles.
  - Response: 16 val_chg pulses, delta=1 each, bin_val follows 0..15..0, err_jump=0, jump_cnt=0.
- Illegal jump:
  - Stimulus: bin_val=0, gray_in 4'b0000 -> 4'b0010 (bin 3).
  - Response: delta=3, val_chg pulse, err_jump=1, jump_cnt=1. A subsequent legal step leaves err_jump=1.
- Clear collision and saturation:
  - Stimulus: assert clr_err on the same edge as an illegal jump.
  - Response: err_jump=1, jump_cnt=1. With clr_err alone: 0/0.
  - Stimulus: force 300 illegal jumps.
  - Response: jump_cnt=255.
- Reset mid-run:
  - Stimulus: pull rstb low during TRACK with bin_val=9, err_jump=1.
  - Response: all outputs 0 immediately without a clk edge; after release, ready returns 3 edges later.
